// File: rtl/score_display.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// score_display
//
// Converts a 14-bit binary score to four BCD digits with a sequential
// shift-and-add-3 engine, then scans the digits onto a multiplexed,
// active-low seven-segment display. Leading zeros are blanked and each digit
// can be blinked individually.
//
// Ports
//   master_clk  system clock, rising edge
//   rst         synchronous, active-high reset
//   clk_fast    divided scan clock, sampled as data
//   clk_blink   divided blink clock, sampled as data
//   score       binary value to display (clamped to 9999)
//   score_load  one-cycle capture request, ignored while busy
//   blink_en    per-digit blink mask, bit 0 = units
//   busy        high while a conversion is running
//   seg         active-low segments {dp,g,f,e,d,c,b,a}
//   an          active-low digit anodes, an[0] = units
// ---------------------------------------------------------------------------
module score_display #(
  parameter int unsigned SCAN_DIGITS = 4
) (
  input  logic        master_clk,
  input  logic        rst,
  input  logic        clk_fast,
  input  logic        clk_blink,
  input  logic [13:0] score,
  input  logic        score_load,
  input  logic [3:0]  blink_en,
  output logic        busy,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned IDX_W     = $clog2(SCAN_DIGITS);
  localparam logic [13:0] MAX_SCORE = 14'd9999;
  localparam logic [3:0]  LAST_ITER = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  // -------------------------------------------------------------------------
  // Segment encoding, active low {dp,g,f,e,d,c,b,a}; dp is always off.
  // -------------------------------------------------------------------------
  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = 8'hC0;
      4'd1:    seg_encode = 8'hF9;
      4'd2:    seg_encode = 8'hA4;
      4'd3:    seg_encode = 8'hB0;
      4'd4:    seg_encode = 8'h99;
      4'd5:    seg_encode = 8'h92;
      4'd6:    seg_encode = 8'h82;
      4'd7:    seg_encode = 8'hF8;
      4'd8:    seg_encode = 8'h80;
      4'd9:    seg_encode = 8'h90;
      default: seg_encode = 8'hFF;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Conversion state
  // -------------------------------------------------------------------------
  state_t      state_q;
  logic        busy_q;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  cnt_q;
  logic [15:0] disp_q;

  logic [13:0] score_clamped;
  logic [14:0] bcd_adj;

  assign score_clamped = (score > MAX_SCORE) ? MAX_SCORE : score;

  // Add-3 correction ahead of each shift. The thousands nibble is never
  // corrected: with the input clamped to 9999 it stays below 5 before every
  // shift, so only its low three bits ever move up into bit 15.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    bcd_adj = bcd_q[14:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge master_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (score_load) begin
            bin_q   <= score_clamped;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_q <= {bcd_adj, bin_q[13]};
          bin_q <= {bin_q[12:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_ITER) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // All four digits land in one edge, so the display never shows a
          // mix of old and new digits.
          disp_q  <= bcd_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;

  // -------------------------------------------------------------------------
  // Scan and blink
  // -------------------------------------------------------------------------
  logic             fast_q;
  logic             fast_qq;
  logic             blink_q;
  logic             scan_tick;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       an_q;
  logic [7:0]       seg_q;

  logic [3:0]       an_d;
  logic [7:0]       seg_d;
  logic [3:0]       digit;
  logic [3:0]       lz_blank;

  assign scan_tick = fast_q & ~fast_qq;

  // A digit is a leading zero when it and every digit above it are zero.
  // The units digit always shows, so a zero score reads "0".
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (disp_q[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (disp_q[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (disp_q[7:4] == 4'd0);
  end

  always_comb begin
    digit = disp_q[3:0];
    case (idx_q)
      2'd0:    digit = disp_q[3:0];
      2'd1:    digit = disp_q[7:4];
      2'd2:    digit = disp_q[11:8];
      default: digit = disp_q[15:12];
    endcase

    an_d = ~(4'b0001 << idx_q);

    // Blink wins over the digit value; leading-zero blanking comes next.
    if (blink_en[idx_q] && !blink_q) begin
      seg_d = 8'hFF;
    end else if (lz_blank[idx_q]) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = seg_encode(digit);
    end
  end

  always_ff @(posedge master_clk) begin
    if (rst) begin
      fast_q  <= 1'b0;
      fast_qq <= 1'b0;
      blink_q <= 1'b0;
      idx_q   <= '0;
      an_q    <= 4'b1111;
      seg_q   <= 8'hFF;
    end else begin
      fast_q  <= clk_fast;
      fast_qq <= fast_q;
      blink_q <= clk_blink;
      if (scan_tick) begin
        idx_q <= idx_q + 1'b1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_score_display.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_score_display
//
// Directed bench for score_display: reset state, scanning, BCD conversion
// timing, clamping, load-while-busy, blinking and reset mid-conversion.
// ---------------------------------------------------------------------------
module tb_score_display;

  logic        master_clk;
  logic        rst;
  logic        clk_fast;
  logic        clk_blink;
  logic [13:0] score;
  logic        score_load;
  logic [3:0]  blink_en;
  logic        busy;
  logic [7:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_pass   = 0;

  score_display #(.SCAN_DIGITS(4)) dut (
    .master_clk (master_clk),
    .rst        (rst),
    .clk_fast   (clk_fast),
    .clk_blink  (clk_blink),
    .score      (score),
    .score_load (score_load),
    .blink_en   (blink_en),
    .busy       (busy),
    .seg        (seg),
    .an         (an)
  );

  initial master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  // Advance one master_clk cycle; inputs are driven and outputs sampled 1 ns
  // after the rising edge.
  task automatic step();
    @(posedge master_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clk_fast period: advances the scan index by exactly one position and
  // leaves enough cycles for the registered an/seg to follow.
  task automatic pulse_fast();
    clk_fast = 1'b1;
    steps(4);
    clk_fast = 1'b0;
    steps(4);
  endtask

  // Walks all four positions starting at the units digit and returns there.
  task automatic check_digits(input string tag, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3);
    check({tag, " an0"},  {4'h0, an}, 8'h0E);
    check({tag, " seg0"}, seg, e0);
    pulse_fast();
    check({tag, " an1"},  {4'h0, an}, 8'h0D);
    check({tag, " seg1"}, seg, e1);
    pulse_fast();
    check({tag, " an2"},  {4'h0, an}, 8'h0B);
    check({tag, " seg2"}, seg, e2);
    pulse_fast();
    check({tag, " an3"},  {4'h0, an}, 8'h07);
    check({tag, " seg3"}, seg, e3);
    pulse_fast();
  endtask

  // Loads a value and follows the busy window T1..T15, then lets seg settle.
  task automatic load_and_wait(input string tag, input logic [13:0] v);
    score      = v;
    score_load = 1'b1;
    step();                       // now in T1
    score_load = 1'b0;
    check({tag, " busy T1"}, {7'd0, busy}, 8'd1);
    steps(14);                    // now in T15
    check({tag, " busy T15"}, {7'd0, busy}, 8'd1);
    step();                       // now in T16
    check({tag, " busy T16"}, {7'd0, busy}, 8'd0);
    steps(2);
  endtask

  initial begin
    rst        = 1'b1;
    clk_fast   = 1'b0;
    clk_blink  = 1'b1;
    score      = '0;
    score_load = 1'b0;
    blink_en   = 4'b0000;

    // Reset state.
    steps(3);
    check("rst busy", {7'd0, busy}, 8'd0);
    check("rst an",   {4'h0, an},   8'h0F);
    check("rst seg",  seg,          8'hFF);

    // First cycle after reset release: units digit showing 0.
    rst = 1'b0;
    step();
    check("post-rst an",  {4'h0, an}, 8'h0E);
    check("post-rst seg", seg,        8'hC0);

    // Scan with no load: only the units digit shows.
    pulse_fast();
    check("scan1 an",  {4'h0, an}, 8'h0D);
    check("scan1 seg", seg,        8'hFF);
    pulse_fast();
    check("scan2 an",  {4'h0, an}, 8'h0B);
    check("scan2 seg", seg,        8'hFF);
    pulse_fast();
    check("scan3 an",  {4'h0, an}, 8'h07);
    check("scan3 seg", seg,        8'hFF);
    pulse_fast();
    check("scan4 an",  {4'h0, an}, 8'h0E);
    check("scan4 seg", seg,        8'hC0);

    // 1234: old value shown through T15, new value afterwards.
    score      = 14'd1234;
    score_load = 1'b1;
    step();
    score_load = 1'b0;
    check("1234 busy T1", {7'd0, busy}, 8'd1);
    steps(14);
    check("1234 busy T15", {7'd0, busy}, 8'd1);
    check("1234 old seg T15", seg, 8'hC0);
    step();
    check("1234 busy T16", {7'd0, busy}, 8'd0);
    steps(2);
    check_digits("1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Clamp above 9999.
    load_and_wait("12000", 14'd12000);
    check_digits("12000", 8'h90, 8'h90, 8'h90, 8'h90);

    // Largest representable input also clamps.
    load_and_wait("16383", 14'd16383);
    check_digits("16383", 8'h90, 8'h90, 8'h90, 8'h90);

    // Load 7, then a load of 50 at T5 must be ignored.
    score      = 14'd7;
    score_load = 1'b1;
    step();                       // T1
    score_load = 1'b0;
    steps(4);                     // T5
    score      = 14'd50;
    score_load = 1'b1;
    step();                       // T6
    score_load = 1'b0;
    steps(9);                     // T15
    check("7 busy T15", {7'd0, busy}, 8'd1);
    step();                       // T16
    check("7 busy T16", {7'd0, busy}, 8'd0);
    steps(20);
    check("7 no restart", {7'd0, busy}, 8'd0);
    check_digits("7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);

    // Blink the units digit of 5.
    load_and_wait("5", 14'd5);
    blink_en  = 4'b0001;
    clk_blink = 1'b1;
    steps(3);
    check("blink hi seg", seg, 8'h92);
    clk_blink = 1'b0;
    steps(3);
    check("blink lo seg", seg, 8'hFF);
    clk_blink = 1'b1;
    steps(3);
    check("blink hi2 seg", seg, 8'h92);
    blink_en = 4'b0000;
    clk_blink = 1'b0;
    steps(3);
    check("blink off seg", seg, 8'h92);
    clk_blink = 1'b1;

    // Reset at T8 of a 4321 conversion: nothing is committed.
    score      = 14'd4321;
    score_load = 1'b1;
    step();                       // T1
    score_load = 1'b0;
    steps(7);                     // T8
    check("4321 busy T8", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    step();
    check("abort busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    steps(20);
    check("abort busy late", {7'd0, busy}, 8'd0);
    check_digits("abort", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter SCAN_DIGITS, default 4, number of multiplexed seven-segment digits (only 4 supported).
REQ-002 SHALL have port master_clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port clk_fast  input  1  divided scan clock from the clock divider, sampled as data in the master_clk domain.
REQ-005 SHALL have port clk_blink  input  1  divided blink clock from the clock divider, sampled as data.
REQ-006 SHALL have port score  input  14  unsigned binary value to display.
REQ-007 SHALL have port score_load  input  1  one-cycle request to capture score.
REQ-008 SHALL have port blink_en  input  4  per-digit blink mask; bit 0 is the units digit.
REQ-009 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-010 SHALL have port seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-011 SHALL have port an  output  4  active-low digit anodes; an[0] is the units digit.

Function
REQ-012 SHALL register clk_fast and clk_blink once; scan_tick = clk_fast_q & ~clk_fast_qq (one master_clk pulse per clk_fast rising edge).
REQ-013 SHALL run FSM IDLE -> SHIFT -> DONE -> IDLE for binary-to-BCD conversion (shift-and-add-3).
REQ-014 SHALL, in IDLE, on score_load=1 at cycle T0, capture min(score, 9999) and enter SHIFT at T1.
REQ-015 SHALL perform exactly 14 SHIFT iterations (T1..T14); before each shift, add 3 to any BCD nibble >= 5.
REQ-016 SHALL, in DONE (T15), commit all four BCD digits to the display register in one cycle (atomic update), visible from T16.
REQ-017 SHALL drive busy=1 from T1 through T15 inclusive, busy=0 otherwise.
REQ-018 SHALL ignore score_load while busy=1 (no queuing, no restart).
REQ-019 SHALL clamp score > 9999 to 9999.
REQ-020 SHALL hold a 2-bit digit index, incremented on each scan_tick, wrapping 3 -> 0.
REQ-021 SHALL register an and seg every cycle from the current index and display register; an = one-hot-low of index (index 0 -> 4'b1110).
REQ-022 SHALL encode digits 0-9 as seg C0,F9,A4,B0,99,92,82,F8,80,90 (hex); dp (seg[7]) always 1.
REQ-023 SHALL blank (seg=FF) leading zeros above the most significant non-zero digit; the units digit is never leading-zero blanked.
REQ-024 SHALL blank digit i (seg=FF) when blink_en[i]=1 and registered clk_blink=0; blink overrides digit value.
REQ-025 SHALL treat scan_tick and score_load in the same cycle independently; neither delays the other.
REQ-026 SHALL keep the display register unchanged during conversion; old value is shown until T16.

Reset
REQ-027 SHALL, while rst=1: FSM=IDLE, busy=0, display register=0000, index=0, edge/blink registers=0, an=1111, seg=FF.
REQ-028 SHALL, on rst mid-conversion, abort the conversion and discard partial results; display register reads 0000.
REQ-029 SHALL, in the first cycle after rst deasserts, output an=1110, seg=C0 (value 0, units digit).

Verification
REQ-030 SHALL cover: reset, no load, 4 clk_fast edges -> an 1110,1101,1011,0111; seg C0 at 1110, FF at the others.
REQ-031 SHALL cover: load 1234 at T0 -> busy high T1..T15; from T16 seg 99@1110, B0@1101, A4@1011, F9@0111.
REQ-032 SHALL cover: load 12000 -> display 9999, seg 90 on all four digits.
REQ-033 SHALL cover: load 7, then load 50 at T5 -> second load ignored; display 0007: F8 on units, FF on others.
REQ-034 SHALL cover: display 5, blink_en=0001 -> units seg FF while clk_blink=0, 92 while clk_blink=1.
REQ-035 SHALL cover: load 4321, rst at T8 -> busy=0 next cycle, display 0000, no commit at T15.
